// File: rtl/eth_rx_filter_pkg.sv
// eth_rx_filter_pkg: shared state encoding, header length and helpers for the RX MAC filter
package eth_rx_filter_pkg;

    localparam int          HDR_LEN   = 6;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/eth_mac_match.sv
// eth_mac_match: combinational destination-address acceptance decision
module eth_mac_match
    import eth_rx_filter_pkg::*;
#(
    parameter bit BCAST_EN = 1'b1
) (
    input  logic [47:0] dest_i,
    input  logic [47:0] local_mac_i,
    input  logic        promisc_i,
    input  logic        mcast_en_i,
    output logic        match_o
);

    // dest_i[40] is the group bit: bit 0 of the first byte on the wire
    assign match_o = promisc_i | (dest_i == local_mac_i) | (BCAST_EN & (dest_i == MAC_BCAST)) | (mcast_en_i & dest_i[40]);

endmodule

// File: rtl/eth_rx_mac_filter.sv
// eth_rx_mac_filter: buffers the destination MAC, decides pass/drop, replays the header and streams the rest.
// Optional statistics counters are enabled by defining ETH_RX_MAC_FILTER_STATS_EN.
module eth_rx_mac_filter
    import eth_rx_filter_pkg::*;
#(
    parameter bit BCAST_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic [47:0] local_mac,
    input  logic        promisc,
    input  logic        mcast_en,
    output logic        frame_pass,
    output logic        frame_drop,
    output logic        frame_runt
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] pass_count,
    output logic [31:0] drop_count,
    output logic [31:0] runt_count
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(HDR_LEN - 1);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d, rd_q, rd_d;
    logic [7:0]  hdr_q [HDR_LEN];
    logic [7:0]  hdr_d [HDR_LEN];
    logic        last_q, last_d, user_q, user_d, rdy_q;
    logic        m_valid_q, m_valid_d, m_last_q, m_last_d, m_user_q, m_user_d;
    logic [7:0]  m_data_q, m_data_d;
    logic [47:0] dest;
    logic        match, s_hs;

    assign dest = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis_tdata};
    assign s_hs = s_axis_tvalid & s_axis_tready;

    eth_mac_match #(.BCAST_EN(BCAST_EN)) u_match (
        .dest_i      (dest),
        .local_mac_i (local_mac),
        .promisc_i   (promisc),
        .mcast_en_i  (mcast_en),
        .match_o     (match)
    );

    // Stream muxing: PASS is a wire-through, every other state drives the registered replay port
    always_comb begin
        s_axis_tready = (state_q == PASS) ? m_axis_tready : rdy_q & (state_q != REPLAY);
        m_axis_tvalid = (state_q == PASS) ? s_axis_tvalid : m_valid_q;
        m_axis_tdata  = (state_q == PASS) ? s_axis_tdata : m_data_q;
        m_axis_tlast  = (state_q == PASS) ? s_axis_tlast : m_last_q;
        m_axis_tuser  = (state_q == PASS) ? s_axis_tuser : m_user_q;
    end

    // Next-state, header capture, replay sequencing and per-frame status pulses
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_d       = rd_q;
        hdr_d      = hdr_q;
        last_d     = last_q;
        user_d     = user_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_user_d   = m_user_q;
        frame_pass = 1'b0;
        frame_drop = 1'b0;
        frame_runt = 1'b0;
        case (state_q)
            HDR: if (s_hs) begin
                hdr_d[idx_q] = s_axis_tdata;
                idx_d        = idx_q + 3'd1;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    last_d = s_axis_tlast;
                    user_d = s_axis_tuser;
                    if (match) begin
                        state_d   = REPLAY;
                        rd_d      = '0;
                        m_valid_d = 1'b1;
                        m_data_d  = hdr_q[0];
                        m_last_d  = 1'b0;
                        m_user_d  = 1'b0;
                    end else if (s_axis_tlast) begin
                        frame_drop = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end else if (s_axis_tlast) begin
                    idx_d      = '0;
                    frame_runt = 1'b1;
                end
            end
            REPLAY: if (m_valid_q & m_axis_tready) begin
                if (rd_q == LAST_IDX) begin
                    state_d    = last_q ? HDR : PASS;
                    frame_pass = last_q;
                    m_valid_d  = 1'b0;
                    m_data_d   = '0;
                    m_last_d   = 1'b0;
                    m_user_d   = 1'b0;
                end else begin
                    rd_d     = rd_q + 3'd1;
                    m_data_d = hdr_q[rd_d];
                    m_last_d = last_q & (rd_d == LAST_IDX);
                    m_user_d = user_q & (rd_d == LAST_IDX);
                end
            end
            PASS: if (s_axis_tvalid & m_axis_tready & s_axis_tlast) begin
                state_d    = HDR;
                idx_d      = '0;
                frame_pass = 1'b1;
            end
            DROP: if (s_hs & s_axis_tlast) begin
                state_d    = HDR;
                frame_drop = 1'b1;
            end
            default: state_d = HDR;
        endcase
    end

    // State and datapath registers; rdy_q holds the input closed until the first clock after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HDR;
            idx_q     <= '0;
            rd_q      <= '0;
            hdr_q     <= '{default: '0};
            last_q    <= 1'b0;
            user_q    <= 1'b0;
            rdy_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            hdr_q     <= hdr_d;
            last_q    <= last_d;
            user_q    <= user_d;
            rdy_q     <= 1'b1;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
        end
    end

`ifdef ETH_RX_MAC_FILTER_STATS_EN
    // Saturating per-outcome counters; a clear overrides a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            drop_count <= '0;
            runt_count <= '0;
        end else if (stat_clr) begin
            pass_count <= '0;
            drop_count <= '0;
            runt_count <= '0;
        end else begin
            pass_count <= frame_pass ? sat_inc(pass_count) : pass_count;
            drop_count <= frame_drop ? sat_inc(drop_count) : drop_count;
            runt_count <= frame_runt ? sat_inc(runt_count) : runt_count;
        end
    end
`endif

endmodule
